// File: rtl/quad_step_decoder_pkg.sv
// Shared types and constants for the quadrature step decoder.
// Glitch filtering is compiled in when QDEC_GLITCH_FILT_EN is defined.
package qdec_pkg;

    typedef enum logic {INIT, TRACK} qdec_state_t;

    localparam logic [1:0] QD_00 = 2'b00;
    localparam logic [1:0] QD_01 = 2'b01;
    localparam logic [1:0] QD_11 = 2'b11;
    localparam logic [1:0] QD_10 = 2'b10;

    localparam int QD_ERR_W = 8;

    // Next code in the up direction of the 00-01-11-10 cycle.
    function automatic logic [1:0] qd_next_up(input logic [1:0] code);
        case (code)
            QD_00:   return QD_01;
            QD_01:   return QD_11;
            QD_11:   return QD_10;
            default: return QD_00;
        endcase
    endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// Encoder pins and decoded step/direction/error outputs of the quadrature decoder.
interface quad_step_decoder_if
    import qdec_pkg::*;
    #(parameter int ERR_W = QD_ERR_W);

    logic             enc_a;
    logic             enc_b;
    logic             step;
    logic             up_or_down;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    modport master (output enc_a, enc_b, input step, up_or_down, err, err_cnt);
    modport slave  (input enc_a, enc_b, output step, up_or_down, err, err_cnt);

endinterface

// File: rtl/quad_step_decoder_chan_filt.sv
// One encoder channel: synchronizer chain, plus a stability filter when
// QDEC_GLITCH_FILT_EN is defined.
module qdec_chan_filt #(
    parameter int SYNC_STAGES = 2
`ifdef QDEC_GLITCH_FILT_EN
    , parameter int FILT_LEN  = 4
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], din};
    end

`ifdef QDEC_GLITCH_FILT_EN
    localparam logic [7:0] FILT_TC = 8'(FILT_LEN - 1);

    logic [7:0] cnt;
    logic       filt;

    // The filtered value moves only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (sync[SYNC_STAGES-1] != filt) begin
            if (cnt == FILT_TC) begin
                filt <= sync[SYNC_STAGES-1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end else begin
            cnt <= '0;
        end
    end

    assign dout = filt;
`else
    assign dout = sync[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: Gray transitions to step/direction, illegal jumps to err.
// QDEC_GLITCH_FILT_EN enables the per-channel glitch filter.
//
// state | meaning
// INIT  | pipeline flushing after reset; no step/err, prev captured at the end
// TRACK | decode cur against prev every cycle
module quad_step_decoder
    import qdec_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int ERR_W       = QD_ERR_W
) (
    input  logic                clk,
    input  logic                reset,
    quad_step_decoder_if.slave  bus
);

`ifdef QDEC_GLITCH_FILT_EN
    localparam int FILT_EN = 1;
`else
    localparam int FILT_EN = 0;
`endif
    localparam int          INIT_LEN = SYNC_STAGES + FILT_EN * FILT_LEN;
    localparam logic [15:0] INIT_TC  = 16'(INIT_LEN);

    logic             fa, fb;
    logic [1:0]       cur, prev;
    qdec_state_t      state;
    logic [15:0]      init_cnt;
    logic             step_q, err_q, dir_q;
    logic [ERR_W-1:0] err_cnt_q;

`ifdef QDEC_GLITCH_FILT_EN
    qdec_chan_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
        .clk(clk), .reset(reset), .din(bus.enc_a), .dout(fa));
    qdec_chan_filt #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
        .clk(clk), .reset(reset), .din(bus.enc_b), .dout(fb));
`else
    qdec_chan_filt #(.SYNC_STAGES(SYNC_STAGES)) u_filt_a (
        .clk(clk), .reset(reset), .din(bus.enc_a), .dout(fa));
    qdec_chan_filt #(.SYNC_STAGES(SYNC_STAGES)) u_filt_b (
        .clk(clk), .reset(reset), .din(bus.enc_b), .dout(fb));
`endif

    assign cur = {fa, fb};

    // Counting down from INIT_LEN to 0 gives the pins one extra cycle so prev
    // sees a fully flushed pipeline even if they idle at a non-zero code.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            init_cnt  <= INIT_TC;
            prev      <= QD_00;
            step_q    <= 1'b0;
            err_q     <= 1'b0;
            dir_q     <= 1'b1;
            err_cnt_q <= '0;
        end else begin
            step_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                INIT: begin
                    if (init_cnt == 16'd0) begin
                        prev  <= cur;
                        state <= TRACK;
                    end else begin
                        init_cnt <= init_cnt - 16'd1;
                    end
                end
                TRACK: begin
                    prev <= cur;
                    if (cur == qd_next_up(prev)) begin
                        step_q <= 1'b1;
                        dir_q  <= 1'b1;
                    end else if (prev == qd_next_up(cur)) begin
                        step_q <= 1'b1;
                        dir_q  <= 1'b0;
                    end else if (cur != prev) begin
                        err_q <= 1'b1;
                        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + ERR_W'(1);
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    assign bus.step       = step_q;
    assign bus.err        = err_q;
    assign bus.up_or_down = dir_q;
    assign bus.err_cnt    = err_cnt_q;

endmodule
